// File: rtl/sif_arb.sv
// sif_arb: shares the single SIF access port of the decode buffer/register map
// between NREQ requesters. The winner owns the bus for one burst. Its beats go out
// on sif_addr/sif_wen/sif_ren, and read data comes back one cycle later to
// whichever requester issued the read.
// Optional feature macro: SIF_ARB_RR_EN. When it is defined, arbitration is
// round-robin and a start pointer rotates on every release. When it is
// undefined, arbitration is fixed priority and the lowest valid index wins.
module sif_arb #(
  parameter int NREQ      = 2,
  parameter int SIF_AW    = 22,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*SIF_AW-1:0] req_addr,
  input  logic [NREQ*32-1:0]     req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic [SIF_AW-1:0]      sif_addr,
  output logic                   sif_wen,
  output logic [31:0]            sif_wdata,
  output logic                   sif_ren,
  input  logic [31:0]            sif_rdata
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rsp_sel_q, rsp_sel_d;

  logic [GW-1:0]     search_start;
  logic [2*NREQ-1:0] valid_dbl;
  logic [NREQ-1:0]   valid_rot;
  logic [GW-1:0]     pick;
  logic              pick_found;
  logic [NREQ-1:0]   gnt_onehot;
  logic              busy;
  logic              accept;
  logic              release_beat;
  logic [CW-1:0]     cnt_inc;

`ifdef SIF_ARB_RR_EN
  logic [GW-1:0] ptr_q, ptr_d;

  assign search_start = ptr_q;
`else
  assign search_start = '0;
`endif

  // Rotate the request vector so bit 0 corresponds to the search start index.
  assign valid_dbl = {req_valid, req_valid} >> search_start;
  assign valid_rot = valid_dbl[NREQ-1:0];

  // Find the first valid requester at or above the start index, wrapping
  // around. The downward loop lets the closest candidate overwrite the others.
  always_comb begin
    pick       = search_start;
    pick_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        pick       = GW'((int'(search_start) + i) % NREQ);
        pick_found = 1'b1;
      end
    end
  end

  // Decode the granted index to one-hot. This drives req_ready and tags read returns.
  always_comb begin
    gnt_onehot        = '0;
    gnt_onehot[gnt_q] = 1'b1;
  end

  assign busy         = (state_q == BUSY);
  assign accept       = busy && req_valid[gnt_q];
  assign cnt_inc      = cnt_q + CW'(1);
  assign release_beat = accept && (req_last[gnt_q] || (cnt_inc == CW'(MAX_BURST)));

  // Grant in IDLE. In BUSY, count accepted beats and drop back to IDLE on release.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      if (pick_found) begin
        state_d = BUSY;
        gnt_d   = pick;
        cnt_d   = '0;
      end
    end else if (accept) begin
      cnt_d = cnt_inc;
      if (release_beat) begin
        state_d = IDLE;
      end
    end
  end

  // Tag each read strobe with its requester so the data can be routed back next cycle.
  assign rsp_sel_d = (accept && !req_we[gnt_q]) ? gnt_onehot : '0;

  // Main state registers. A synchronous reset also cancels any pending read return.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      cnt_q     <= '0;
      rsp_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      rsp_sel_q <= rsp_sel_d;
    end
  end

`ifdef SIF_ARB_RR_EN
  assign ptr_d = release_beat ? GW'((int'(gnt_q) + 1) % NREQ) : ptr_q;

  // The round-robin start pointer moves just past the requester that released.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Outputs are forced to zero while rstn is low, even before the state
  // registers have seen a reset edge.
  assign req_ready = (rstn && busy) ? gnt_onehot : '0;
  assign sif_wen   = rstn && accept && req_we[gnt_q];
  assign sif_ren   = rstn && accept && !req_we[gnt_q];
  assign sif_addr  = rstn ? req_addr[int'(gnt_q)*SIF_AW +: SIF_AW] : '0;
  assign sif_wdata = rstn ? req_wdata[int'(gnt_q)*32 +: 32] : '0;
  assign rsp_valid = rstn ? rsp_sel_q : '0;
  assign rsp_rdata = (rstn && (|rsp_sel_q)) ? sif_rdata : '0;

endmodule

// File: tb/tb_sif_arb.sv
// tb_sif_arb: directed scenarios followed by a randomized run of sif_arb
// (NREQ=2, MAX_BURST=4). On every cycle the outputs are checked against a
// transaction-level model of bus ownership. The directed scenarios add literal
// expectations that pin that model.
// The expectations follow SIF_ARB_RR_EN in the same way the design does.
module tb_sif_arb;
  localparam int NREQ = 2;
  localparam int AW   = 22;
  localparam int MAXB = 4;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_we = '0;
  logic [NREQ-1:0]     req_last = '0;
  logic [NREQ*AW-1:0]  req_addr = '0;
  logic [NREQ*32-1:0]  req_wdata = '0;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_rdata;
  logic [AW-1:0]       sif_addr;
  logic                sif_wen;
  logic [31:0]         sif_wdata;
  logic                sif_ren;
  logic [31:0]         sif_rdata = '0;

  always #5 clk = ~clk;

  sif_arb #(.NREQ(NREQ), .SIF_AW(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sif_addr(sif_addr), .sif_wen(sif_wen), .sif_wdata(sif_wdata),
    .sif_ren(sif_ren), .sif_rdata(sif_rdata)
  );

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model of bus ownership. mOwner is the granted requester, mBusy
  // says whether a burst is open, and mPend is the requester whose read data
  // is due this cycle (-1 if none).
  bit mBusy  = 1'b0;
  int mOwner = 0;
  int mPtr   = 0;
  int mBeats = 0;
  int mPend  = -1;
  int mStart;

  always @(posedge clk) begin
    if (!rstn) begin
      mBusy = 1'b0; mOwner = 0; mPtr = 0; mBeats = 0; mPend = -1;
    end else begin
      mPend = -1;
      if (mBusy) begin
        if (req_valid[mOwner]) begin
          if (!req_we[mOwner]) mPend = mOwner;
          mBeats = mBeats + 1;
          if (req_last[mOwner] || mBeats == MAXB) begin
            mBusy = 1'b0;
            mPtr  = (mOwner + 1) % NREQ;
          end
        end
      end else begin
`ifdef SIF_ARB_RR_EN
        mStart = mPtr;
`else
        mStart = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
          if (!mBusy && req_valid[(mStart + k) % NREQ]) begin
            mBusy  = 1'b1;
            mOwner = (mStart + k) % NREQ;
            mBeats = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare process. It samples mid-cycle while the inputs and the
  // DUT state are stable.
  logic [NREQ-1:0] expReady;
  logic [NREQ-1:0] expRsp;
  bit              expAcc;

  always @(negedge clk) begin
    if (!rstn) begin
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_sif_wen", sif_wen, 0);
      checkOutput("rst_sif_ren", sif_ren, 0);
      checkOutput("rst_sif_addr", sif_addr, 0);
      checkOutput("rst_sif_wdata", sif_wdata, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    end else begin
      expReady = mBusy ? NREQ'(1 << mOwner) : '0;
      expAcc   = mBusy && req_valid[mOwner];
      checkOutput("req_ready", req_ready, expReady);
      checkOutput("sif_wen", sif_wen, expAcc && req_we[mOwner]);
      checkOutput("sif_ren", sif_ren, expAcc && !req_we[mOwner]);
      if (mBusy) begin
        checkOutput("sif_addr", sif_addr, req_addr[mOwner*AW +: AW]);
        checkOutput("sif_wdata", sif_wdata, req_wdata[mOwner*32 +: 32]);
      end
      expRsp = (mPend >= 0) ? NREQ'(1 << mPend) : '0;
      checkOutput("rsp_valid", rsp_valid, expRsp);
      checkOutput("rsp_rdata", rsp_rdata, (mPend >= 0) ? sif_rdata : 32'h0);
    end
  end

  // Per-requester burst generators used by applyStimulus.
  int beat [NREQ];
  int len  [NREQ];
  logic [NREQ-1:0] holdValid = '0;
  logic [NREQ-1:0] dirWe = '0;
  int grantIdx[$];
  int grantCyc[$];
  logic [NREQ-1:0] readyHist [64];

  task automatic applyStimulus(input int cycles, input bit rnd);
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] prevReady;
    prevReady = '0;
    grantIdx.delete();
    grantCyc.delete();
    for (int n = 0; n < cycles; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = rnd ? ($urandom_range(0, 3) != 0) : holdValid[i];
        req_we[i]    = rnd ? 1'($urandom_range(0, 1)) : dirWe[i];
        req_last[i]  = (beat[i] == len[i] - 1);
        req_addr[i*AW +: AW]  = AW'($urandom);
        req_wdata[i*32 +: 32] = $urandom;
      end
      if (rnd) begin
        sif_rdata = $urandom;
        rstn = ($urandom_range(0, 80) != 0);
      end
      @(negedge clk);
      acc = req_valid & req_ready;
      if (n < 64) readyHist[n] = req_ready;
      if (req_ready != '0 && prevReady == '0) begin
        grantIdx.push_back(req_ready[1] ? 1 : 0);
        grantCyc.push_back(n);
      end
      prevReady = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          beat[i]++;
          if (beat[i] >= len[i]) begin
            beat[i] = 0;
            if (rnd) len[i] = $urandom_range(1, 6);
          end
        end
      end
    end
  endtask

  task automatic doReset();
    rstn = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_sif_addr", sif_addr, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  int expSecond;

  initial begin
    // Single write from requester 0
    doReset();
    req_valid = 2'b01; req_we = 2'b01; req_last = 2'b01;
    req_addr[0 +: AW] = 22'h080004; req_wdata[0 +: 32] = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("t1_idle_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1_ready", req_ready, 2'b01);
    checkOutput("t1_wen", sif_wen, 1'b1);
    checkOutput("t1_ren", sif_ren, 1'b0);
    checkOutput("t1_addr", sif_addr, 22'h080004);
    checkOutput("t1_wdata", sif_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("t1_after_ready", req_ready, 2'b00);
    checkOutput("t1_after_wen", sif_wen, 1'b0);
    @(posedge clk); #1;

    // Read by requester 1 on its last beat; data returns while already idle
    req_valid = 2'b10; req_we = 2'b00; req_last = 2'b10;
    req_addr[AW +: AW] = 22'h140000;
    @(negedge clk);
    checkOutput("t2_idle_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t2_ready", req_ready, 2'b10);
    checkOutput("t2_ren", sif_ren, 1'b1);
    checkOutput("t2_addr", sif_addr, 22'h140000);
    @(posedge clk); #1;
    req_valid = 2'b00;
    sif_rdata = 32'h12345678;
    @(negedge clk);
    checkOutput("t2_rsp_valid", rsp_valid, 2'b10);
    checkOutput("t2_rsp_rdata", rsp_rdata, 32'h12345678);
    checkOutput("t2_idle_after_last", req_ready, 2'b00);
    checkOutput("t2_ren_clear", sif_ren, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t2_rsp_done", rsp_valid, 2'b00);
    checkOutput("t2_rdata_zero", rsp_rdata, 32'h0);
    @(posedge clk); #1;

    // Contention: both requesters keep 3-beat write bursts going
    doReset();
    beat[0] = 0; beat[1] = 0; len[0] = 3; len[1] = 3;
    holdValid = 2'b11; dirWe = 2'b11;
    applyStimulus(17, 1'b0);
    checkOutput("t3_grant_count", grantIdx.size() >= 4, 1'b1);
    if (grantIdx.size() >= 4) begin
      for (int g = 0; g < 4; g++) begin
`ifdef SIF_ARB_RR_EN
        checkOutput("t3_grant_idx", grantIdx[g], g % 2);
`else
        checkOutput("t3_grant_idx", grantIdx[g], 0);
`endif
        checkOutput("t3_grant_cycle", grantCyc[g], 1 + 4 * g);
      end
    end

    // Forced release: requester 0 never flags last
    doReset();
    beat[0] = 0; beat[1] = 0; len[0] = 1000; len[1] = 1;
    holdValid = 2'b11; dirWe = 2'b00;
    applyStimulus(10, 1'b0);
    checkOutput("t4_beat4_ready", readyHist[4], 2'b01);
    checkOutput("t4_gap_ready", readyHist[5], 2'b00);
    checkOutput("t4_grant_count", grantIdx.size() >= 2, 1'b1);
    if (grantIdx.size() >= 2) begin
`ifdef SIF_ARB_RR_EN
      expSecond = 1;
`else
      expSecond = 0;
`endif
      checkOutput("t4_first_idx", grantIdx[0], 0);
      checkOutput("t4_second_idx", grantIdx[1], expSecond);
      checkOutput("t4_second_cycle", grantCyc[1], 6);
    end

    // Stall mid-burst, then a read, then reset while a return is pending
    doReset();
    req_valid = 2'b01; req_we = 2'b01; req_last = 2'b00;
    req_addr[0 +: AW] = 22'h000123;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t5_first_beat", sif_wen, 1'b1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput("t5_stall_ready", req_ready, 2'b01);
      checkOutput("t5_stall_wen", sif_wen, 1'b0);
      checkOutput("t5_stall_ren", sif_ren, 1'b0);
      @(posedge clk); #1;
    end
    req_valid = 2'b01; req_we = 2'b00;
    @(negedge clk);
    checkOutput("t5_read_ren", sif_ren, 1'b1);
    @(posedge clk); #1;
    rstn = 1'b0;
    sif_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("t5_rst_rsp_valid", rsp_valid, 2'b00);
    checkOutput("t5_rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("t5_rst_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("t5_idle_ready", req_ready, 2'b00);
    checkOutput("t5_idle_rsp", rsp_valid, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t5_regrant", req_ready, 2'b01);
    @(posedge clk); #1;

    // Randomized traffic with occasional resets
    doReset();
    for (int i = 0; i < NREQ; i++) begin
      beat[i] = 0;
      len[i]  = $urandom_range(1, 6);
    end
    applyStimulus(4000, 1'b1);
    rstn = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
